// File: rtl/nrzi_serial_tx.sv
// nrzi_serial_tx: parallel-in, NRZI serial-out transmitter, LSB first.
// A data bit of 1 toggles the line and a data bit of 0 holds it.
// Define NRZI_TX_STUFF_EN to add bit stuffing: after STUFF_RUN consecutive
// 0 data bits, a forced transition (stuff bit) is inserted on the line.
`timescale 1ns/1ps
module nrzi_serial_tx #(
  parameter int DATA_W     = 8,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int STUFF_RUN  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              tx_active,
  output logic              word_done
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              accept;

  assign last_bit = (bit_cnt == LAST_BIT);
  assign accept   = data_valid && data_ready;

`ifdef NRZI_TX_STUFF_EN
  localparam int RUN_W = $clog2(STUFF_RUN + 1);

  logic [RUN_W-1:0] run_cnt;
  logic             stuff_pending;
  logic             stuff_tail;
  logic             stuff_hit;

  // The bit about to be driven is a 0 that completes a run of STUFF_RUN zeros.
  assign stuff_hit = !shreg[0] && (run_cnt == RUN_W'(STUFF_RUN - 1));

  // Ready in IDLE, before the last data bit when no stuff follows it,
  // or before a trailing stuff bit so the next word still follows without a gap.
  assign data_ready = (state == S_IDLE) ||
                      ((state == S_SEND) &&
                       ((!stuff_pending && last_bit && !stuff_hit) ||
                        (stuff_pending && stuff_tail)));

  // Single state machine: handshake, shifting, NRZI line, stuffing and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      run_cnt       <= '0;
      stuff_pending <= 1'b0;
      stuff_tail    <= 1'b0;
      tx_out        <= IDLE_LEVEL;
      tx_active     <= 1'b0;
      word_done     <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_active <= 1'b0;
          run_cnt   <= '0;
          if (accept) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          tx_active <= 1'b1;
          if (stuff_pending) begin
            // Stuff cycle: forced transition, shift register holds.
            tx_out        <= ~tx_out;
            stuff_pending <= 1'b0;
            run_cnt       <= '0;
            if (stuff_tail) begin
              stuff_tail <= 1'b0;
              if (accept) begin
                shreg   <= data_in;
                bit_cnt <= '0;
              end else begin
                state <= S_IDLE;
              end
            end
          end else begin
            tx_out  <= tx_out ^ shreg[0];
            run_cnt <= shreg[0] ? '0 : run_cnt + RUN_W'(1);
            if (stuff_hit) stuff_pending <= 1'b1;
            if (last_bit) begin
              word_done <= 1'b1;
              if (stuff_hit) begin
                stuff_tail <= 1'b1;
              end else if (accept) begin
                shreg   <= data_in;
                bit_cnt <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_stuff_run;
  assign unused_stuff_run = (STUFF_RUN > 0);

  // Ready in IDLE, and in the cycle before the last data bit goes out so
  // consecutive words run back to back.
  assign data_ready = (state == S_IDLE) || ((state == S_SEND) && last_bit);

  // Single state machine: handshake, shifting, NRZI line and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx_out    <= IDLE_LEVEL;
      tx_active <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_active <= 1'b0;
          if (accept) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          tx_active <= 1'b1;
          tx_out    <= tx_out ^ shreg[0];
          if (last_bit) begin
            word_done <= 1'b1;
            if (accept) begin
              shreg   <= data_in;
              bit_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_nrzi_serial_tx.sv
// Testbench for nrzi_serial_tx: scoreboard of expected line levels per
// active cycle, filled when a word is accepted and drained by a monitor.
`timescale 1ns/1ps
module tb_nrzi_serial_tx;

  localparam int DATA_W    = 8;
  localparam int STUFF_RUN = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              tx_out;
  logic              tx_active;
  logic              word_done;

  nrzi_serial_tx #(.DATA_W(DATA_W), .IDLE_LEVEL(1'b0), .STUFF_RUN(STUFF_RUN)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_out(tx_out), .tx_active(tx_active),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic lvl; logic last; } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     wd_cyc[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     act_run = 0;
  int     act_max = 0;
  bit     mon_en = 1'b0;
  logic   line_lvl = 1'b0;
  logic   push_lvl = 1'b0;
  int     model_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected line levels for one accepted word (with stuff bits when enabled).
  task automatic push_word(input logic [DATA_W-1:0] d);
    exp_t e;
    if (sbq.size() == 0) model_run = 0;
    for (int k = 0; k < DATA_W; k++) begin
      push_lvl = push_lvl ^ d[k];
      e.lvl = push_lvl;
      e.last = (k == DATA_W - 1);
      sbq.push_back(e);
`ifdef NRZI_TX_STUFF_EN
      if (d[k]) model_run = 0;
      else      model_run++;
      if (model_run == STUFF_RUN) begin
        push_lvl = ~push_lvl;
        e.lvl = push_lvl;
        e.last = 1'b0;
        sbq.push_back(e);
        model_run = 0;
      end
`endif
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    bit   done;
    logic rdy;
    done = 1'b0;
    data_in = d;
    data_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      rdy = data_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    chk("accept_wait", {31'd0, done}, 32'd1);
    if (done) push_word(d);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0 && !tx_active) done = 1'b1;
    end
    chk("idle_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop one expectation per active cycle, otherwise the line must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_active) begin
        if (sbq.size() == 0) begin
          chk("unexpected_active", {31'd0, tx_active}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("tx_out", {31'd0, tx_out}, {31'd0, mon_e.lvl});
          chk("word_done", {31'd0, word_done}, {31'd0, mon_e.last});
          line_lvl = mon_e.lvl;
        end
        act_run++;
        if (act_run > act_max) act_max = act_run;
      end else begin
        act_run = 0;
        chk("idle_hold", {31'd0, tx_out}, {31'd0, line_lvl});
        chk("idle_word_done", {31'd0, word_done}, 32'd0);
      end
      if (word_done) wd_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    tick(3);
    reset = 1'b0;
    line_lvl = 1'b0;
    push_lvl = 1'b0;
    mon_en = 1'b1;

    // Reset state and idle
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst_tx_out", {31'd0, tx_out}, 32'd0);
      chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
      chk("rst_data_ready", {31'd0, data_ready}, 32'd1);
      chk("rst_word_done", {31'd0, word_done}, 32'd0);
    end

    // Single word A5
    wd_cyc.delete();
    send_word(8'hA5);
    data_valid = 1'b0;
    wait_idle();
    tick(2);
    chk("a5_hold_level", {31'd0, tx_out}, 32'd0);
    chk("a5_done_count", wd_cyc.size(), 32'd1);

    // Back-to-back FF then 01 with data_valid held
    act_max = 0;
    wd_cyc.delete();
    send_word(8'hFF);
    send_word(8'h01);
    data_valid = 1'b0;
    wait_idle();
`ifdef NRZI_TX_STUFF_EN
    chk("b2b_active_run", act_max, 32'd17);
`else
    chk("b2b_active_run", act_max, 32'd16);
`endif
    chk("b2b_done_count", wd_cyc.size(), 32'd2);
    if (wd_cyc.size() == 2) begin
`ifdef NRZI_TX_STUFF_EN
      chk("b2b_done_spacing", wd_cyc[1] - wd_cyc[0], 32'd9);
`else
      chk("b2b_done_spacing", wd_cyc[1] - wd_cyc[0], 32'd8);
`endif
    end

    // Reset during the 4th bit of A5, then 03
    wd_cyc.delete();
    send_word(8'hA5);
    data_valid = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sbq.delete();
    push_lvl = 1'b0;
    line_lvl = 1'b0;
    model_run = 0;
    chk("mid_rst_tx_out", {31'd0, tx_out}, 32'd0);
    chk("mid_rst_tx_active", {31'd0, tx_active}, 32'd0);
    chk("mid_rst_word_done", {31'd0, word_done}, 32'd0);
    chk("mid_rst_data_ready", {31'd0, data_ready}, 32'd1);
    chk("mid_rst_no_done", wd_cyc.size(), 32'd0);
    send_word(8'h03);
    data_valid = 1'b0;
    wait_idle();
    chk("post_rst_done_count", wd_cyc.size(), 32'd1);

    // data_in changes while not ready: only accept-edge words go out
    wd_cyc.delete();
    send_word(8'h3C);
    data_in = 8'h77;
    tick(3);
    send_word(8'hC3);
    data_valid = 1'b0;
    wait_idle();
    chk("hold_done_count", wd_cyc.size(), 32'd2);

    // Reset and valid together: reset wins
    reset = 1'b1;
    data_in = 8'hAA;
    data_valid = 1'b1;
    tick(1);
    reset = 1'b0;
    data_valid = 1'b0;
    tick(4);
    chk("rst_wins_active", {31'd0, tx_active}, 32'd0);
    chk("rst_wins_queue", sbq.size(), 32'd0);
    chk("rst_wins_ready", {31'd0, data_ready}, 32'd1);

`ifdef NRZI_TX_STUFF_EN
    // Stuffing on an all-zero word
    act_max = 0;
    wd_cyc.delete();
    send_word(8'h00);
    data_valid = 1'b0;
    wait_idle();
    chk("stuff_active_run", act_max, 32'd9);
    chk("stuff_done_count", wd_cyc.size(), 32'd1);
`endif

    tick(2);
    chk("queue_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
